sprite_anim_fetch: RTL and testbench
====================================

// Module: sprite_anim_fetch
// PURPOSE
// Upstream stage of the VGA pixel compositor for one animated sprite (e.g. the blue player).
// Sequences animation frames from a clk-cycle prescaler and fetches sprite ROM pixels for the current scan position.
// Outputs one registered pixel with an opaque flag, so the compositor only muxes layers.
// Frame index and sprite position update only at the screen origin, which prevents tearing.
// PARAMETERS
// SPR_W     47           sprite width in pixels
// SPR_H     41           sprite height in pixels
// NFRAMES   6            animation frames; ROM k holds frame k
// TICK_DIV  4_000_000    clk cycles per frame step (40 ms at 100 MHz)
// AW        11           ROM address width; must satisfy SPR_W*SPR_H <= 2**AW
// KEY       12'h428      transparent colour key
// PORTS
// clk        in   1            system clock
// rst        in   1            synchronous, active-high reset
// col_addr   in   10           current scan column from vgac
// row_addr   in   9            current scan row from vgac
// x_pos      in   10           sprite top-left column
// y_pos      in   9            sprite top-left row
// moving     in   1            1 = animate; 0 = return to rest frame
// rom_addr   out  AW           address shared by all NFRAMES ROMs (1-cycle read latency)
// rom_data   in   12*NFRAMES   concatenated ROM outputs; frame k in bits [12k+11:12k]
// frame_idx  out  3            frame currently being displayed
// pix_out    out  12           sprite pixel RGB444
// pix_opaque out  1            1 = compositor must draw pix_out over lower layers
// BEHAVIOUR
// Reset: all outputs 0; FSM in IDLE; prescaler 0; next_frame 0; shadow x/y/frame 0; pipeline cleared.
// Prescaler
// - Counts 0..TICK_DIV-1 only in RUN or STOP.
// - tick = (cnt == TICK_DIV-1), after which cnt wraps to 0.
// - Held at 0 in IDLE.
// FSM, which advances next_frame:
// - IDLE: next_frame = 0. moving=1 -> RUN.
// - RUN: on tick, next_frame = (next_frame == NFRAMES-1) ? 0 : next_frame+1. moving=0 -> STOP.
// - STOP: keeps stepping on tick. If the step lands on 0 -> IDLE. If moving=1 -> RUN with no frame change.
// - tick and a moving change in the same cycle: apply the step first, then the transition.
// Shadow latch
// - Fires when col_addr==0 && row_addr==0.
// - Copies next_frame->frame_idx, x_pos->xs, y_pos->ys.
// - Sprite geometry never changes mid-frame.
// Pipeline (latency 3 clk from col/row to pix_out/pix_opaque):
// - S1 (reg):
//   - inbox = col>=xs && col<xs+SPR_W && row>=ys && row<ys+SPR_H.
//   - Compare in 11/10-bit widths so xs+SPR_W cannot wrap.
//   - rom_addr = inbox ? (row-ys)*SPR_W + (col-xs) : 0.
//   - Carry inbox and frame_idx forward.
// - S2 (reg): ROM data is valid. Delay inbox and frame.
// - S3 (reg):
//   - pix_out = rom_data slice[frame].
//   - pix_opaque = inbox && slice != KEY.
//   - pix_out is forced to 0 when pix_opaque=0.
// Edges
// - A sprite partly off-screen is clipped naturally; no wrap to column 0.
// - A frame index >= NFRAMES is impossible by construction.
// - rst mid-frame: pix_opaque=0 on the next cycle and the FSM returns to IDLE.
// TESTING (TICK_DIV=4, NFRAMES=6, SPR_W=4, SPR_H=3)
// 1. Reset, then moving=1 for 40 clk, pulsing origin every clk.
//    -> frame_idx steps 0,1,2,3,4,5,0,... every 4 clk.
// 2. moving drops at frame 3.
//    -> frames 4,5,0, then IDLE; frame_idx stays 0 and cnt stays 0.
// 3. x_pos=10, y_pos=5; scan col=10..14, row=5.
//    -> rom_addr 0,1,2,3,0. pix_opaque 1,1,1,1,0 three clk later (ROM pixels non-KEY).
// 4. ROM pixel = 12'h428 inside the box.
//    -> pix_opaque=0 and pix_out=0. Neighbouring pixel 12'hFFF -> pix_opaque=1, pix_out=12'hFFF.
// 5. x_pos=1022 and col=1022..1023.
//    -> in box, rom_addr 0,1. Col 0 of the same row is not in box.
// 6. x_pos changes mid-frame (no origin pulse).
//    -> box is unchanged until the next origin pulse. rst asserted mid-scan -> all outputs 0 next clk.

Source files
------------

// File: rtl/sprite_anim_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_anim_fetch
//  Purpose  : Animated sprite frame sequencer and ROM pixel fetch pipeline
//             feeding one registered, keyed pixel to the VGA compositor.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_anim_fetch #(
    parameter int          SPR_W    = 47,
    parameter int          SPR_H    = 41,
    parameter int          NFRAMES  = 6,
    parameter int          TICK_DIV = 4_000_000,
    parameter int          AW       = 11,
    parameter logic [11:0] KEY      = 12'h428
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            col_addr,
    input  logic [8:0]            row_addr,
    input  logic [9:0]            x_pos,
    input  logic [8:0]            y_pos,
    input  logic                  moving,
    output logic [AW-1:0]         rom_addr,
    input  logic [12*NFRAMES-1:0] rom_data,
    output logic [2:0]            frame_idx,
    output logic [11:0]           pix_out,
    output logic                  pix_opaque
);

    localparam int             c_cw         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cw-1:0] c_cnt_max   = c_cw'(TICK_DIV - 1);
    localparam logic [2:0]     c_last_frame = 3'(NFRAMES - 1);
    localparam logic [10:0]    c_spr_w      = 11'(SPR_W);
    localparam logic [9:0]     c_spr_h      = 10'(SPR_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_cw-1:0]   r_cnt;
    logic              w_tick;
    logic [2:0]        r_next_frame, w_next_frame_nxt, w_stepped;

    logic [2:0]        r_frame_idx;
    logic [9:0]        r_xs;
    logic [8:0]        r_ys;

    logic              w_inbox;
    logic [9:0]        w_dx;
    logic [8:0]        w_dy;
    logic [AW-1:0]     w_addr;
    logic [AW-1:0]     r_rom_addr;
    logic              r_s1_inbox, r_s2_inbox;
    logic [2:0]        r_s1_frame, r_s2_frame;
    logic [11:0]       w_slice;
    logic              w_opaque;
    logic [11:0]       r_pix;
    logic              r_opaque;

    // ---------------- prescaler ----------------
    assign w_tick = (r_state != S_IDLE) && (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // ---------------- frame sequencer ----------------
    assign w_stepped = (r_next_frame == c_last_frame) ? 3'd0 : r_next_frame + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_next_frame <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_next_frame <= w_next_frame_nxt;
        end
    end

    // The tick step is resolved before any moving-driven transition.
    always_comb begin
        w_state_nxt      = r_state;
        w_next_frame_nxt = r_next_frame;
        case (r_state)
            S_IDLE: begin
                w_next_frame_nxt = 3'd0;
                if (moving)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_tick)
                    w_next_frame_nxt = w_stepped;
                if (!moving)
                    w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_tick)
                    w_next_frame_nxt = w_stepped;
                if (w_tick && w_stepped == 3'd0)
                    w_state_nxt = S_IDLE;
                else if (moving)
                    w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt      = S_IDLE;
                w_next_frame_nxt = 3'd0;
            end
        endcase
    end

    // ---------------- shadow latch at screen origin ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_idx <= 3'd0;
            r_xs        <= 10'd0;
            r_ys        <= 9'd0;
        end else if (col_addr == 10'd0 && row_addr == 9'd0) begin
            r_frame_idx <= r_next_frame;
            r_xs        <= x_pos;
            r_ys        <= y_pos;
        end
    end

    // ---------------- S1: bounding box and address ----------------
    // One extra bit on the upper bound keeps a sprite near the right or
    // bottom edge clipped instead of wrapping back to column/row 0.
    assign w_inbox = (col_addr >= r_xs) && ({1'b0, col_addr} < ({1'b0, r_xs} + c_spr_w)) &&
                     (row_addr >= r_ys) && ({1'b0, row_addr} < ({1'b0, r_ys} + c_spr_h));
    assign w_dx    = col_addr - r_xs;
    assign w_dy    = row_addr - r_ys;
    assign w_addr  = w_inbox ? AW'(AW'(w_dy) * AW'(SPR_W) + AW'(w_dx)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_s1_inbox <= 1'b0;
            r_s1_frame <= 3'd0;
            r_s2_inbox <= 1'b0;
            r_s2_frame <= 3'd0;
        end else begin
            r_rom_addr <= w_addr;
            r_s1_inbox <= w_inbox;
            r_s1_frame <= r_frame_idx;
            r_s2_inbox <= r_s1_inbox;
            r_s2_frame <= r_s1_frame;
        end
    end

    // ---------------- S3: frame select and colour key ----------------
    always_comb begin
        w_slice = 12'd0;
        for (int k = 0; k < NFRAMES; k++) begin
            if (r_s2_frame == 3'(k))
                w_slice = rom_data[12*k +: 12];
        end
    end

    assign w_opaque = r_s2_inbox && (w_slice != KEY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix    <= 12'd0;
            r_opaque <= 1'b0;
        end else begin
            r_pix    <= w_opaque ? w_slice : 12'd0;
            r_opaque <= w_opaque;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign frame_idx  = r_frame_idx;
    assign pix_out    = r_pix;
    assign pix_opaque = r_opaque;

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_anim_fetch
//  Purpose  : Directed self-checking bench for sprite_anim_fetch (4x3 sprite).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_anim_fetch;

    localparam int          SPR_W    = 4;
    localparam int          SPR_H    = 3;
    localparam int          NFRAMES  = 6;
    localparam int          TICK_DIV = 4;
    localparam int          AW       = 4;
    localparam logic [11:0] KEY      = 12'h428;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [9:0]            col_addr;
    logic [8:0]            row_addr;
    logic [9:0]            x_pos;
    logic [8:0]            y_pos;
    logic                  moving;
    logic [AW-1:0]         rom_addr;
    logic [12*NFRAMES-1:0] rom_data = '0;
    logic [12*NFRAMES-1:0] rom_next;
    logic [2:0]            frame_idx;
    logic [11:0]           pix_out;
    logic                  pix_opaque;

    logic [AW-1:0]         key_addr = 4'hE;
    logic [AW-1:0]         fff_addr = 4'hF;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] ea [8];
    logic          eo [8];
    logic [11:0]   ep [8];

    sprite_anim_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NFRAMES(NFRAMES),
        .TICK_DIV(TICK_DIV), .AW(AW), .KEY(KEY)
    ) dut (
        .clk(clk), .rst(rst), .col_addr(col_addr), .row_addr(row_addr),
        .x_pos(x_pos), .y_pos(y_pos), .moving(moving), .rom_addr(rom_addr),
        .rom_data(rom_data), .frame_idx(frame_idx), .pix_out(pix_out),
        .pix_opaque(pix_opaque)
    );

    always #5 clk = ~clk;

    // ROM image: frame k, address a -> {k+1, A, a}; two addresses overridable.
    function automatic logic [11:0] rom_pix(input int k, input logic [AW-1:0] a,
                                            input logic [AW-1:0] ka, input logic [AW-1:0] fa);
        if (a == ka) return KEY;
        if (a == fa) return 12'hFFF;
        return {4'(k + 1), 4'hA, a};
    endfunction

    always_comb begin
        rom_next = '0;
        for (int k = 0; k < NFRAMES; k++)
            rom_next[12*k +: 12] = rom_pix(k, rom_addr, key_addr, fff_addr);
    end

    always @(posedge clk) rom_data <= rom_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives n columns of one row, then idle positions; checks rom_addr one
    // clk after each input and pix_out/pix_opaque three clk after it.
    task automatic scan(input string name, input logic [9:0] c0, input logic [8:0] r, input int n);
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) begin
                col_addr = c0 + 10'(j);
                row_addr = r;
            end else begin
                col_addr = 10'd700;
                row_addr = 9'd400;
            end
            step();
            if (j < n)
                check($sformatf("%s_addr%0d", name, j), 32'(rom_addr), 32'(ea[j]));
            if (j >= 2) begin
                check($sformatf("%s_opq%0d", name, j - 2), 32'(pix_opaque), 32'(eo[j - 2]));
                check($sformatf("%s_pix%0d", name, j - 2), 32'(pix_out), 32'(ep[j - 2]));
            end
        end
    endtask

    task automatic origin();
        col_addr = 10'd0;
        row_addr = 9'd0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        rst = 1'b1; moving = 1'b0; col_addr = 10'd0; row_addr = 9'd0;
        x_pos = 10'd0; y_pos = 9'd0;
        step(); step();
        check("rst_frame", 32'(frame_idx), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_pix", 32'(pix_out), 32'd0);
        check("rst_opq", 32'(pix_opaque), 32'd0);

        // animation with origin pulsed every clk
        rst = 1'b0; moving = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            e = (i < 2) ? 0 : ((i - 2) / 4) % 6;
            check($sformatf("run_frame%0d", i), 32'(frame_idx), 32'(e));
        end

        // moving drops while frame 3 is shown: 4,5,0 then rest
        moving = 1'b0;
        for (int i = 41; i <= 60; i++) begin
            step();
            e = (i < 42) ? 3 : (i < 46) ? 4 : (i < 50) ? 5 : 0;
            check($sformatf("stop_frame%0d", i), 32'(frame_idx), 32'(e));
        end
        check("idle_cnt", 32'(dut.r_cnt), 32'd0);
        check("idle_state", 32'(dut.r_state), 32'd0);

        // box scan on row 5 starting at column 10
        x_pos = 10'd10; y_pos = 9'd5;
        origin();
        ea = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
        eo = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ep = '{12'h1A0, 12'h1A1, 12'h1A2, 12'h1A3, 12'h000, 12'h000, 12'h000, 12'h000};
        scan("row5", 10'd10, 9'd5, 5);

        // bottom-right corner pixel and the row just below the box
        ea[0] = 4'd11; eo[0] = 1'b1; ep[0] = 12'h1AB;
        scan("corner", 10'd13, 9'd7, 1);
        ea[0] = 4'd0; eo[0] = 1'b0; ep[0] = 12'h000;
        scan("below", 10'd13, 9'd8, 1);

        // colour key inside the box next to a white pixel
        key_addr = 4'd5; fff_addr = 4'd6;
        ea[0] = 4'd5;  eo[0] = 1'b0; ep[0] = 12'h000;
        ea[1] = 4'd6;  eo[1] = 1'b1; ep[1] = 12'hFFF;
        scan("key", 10'd11, 9'd6, 2);
        key_addr = 4'hE; fff_addr = 4'hF;

        // right screen edge: no wrap to column 0
        x_pos = 10'd1022;
        origin();
        ea[0] = 4'd0; eo[0] = 1'b1; ep[0] = 12'h1A0;
        ea[1] = 4'd1; eo[1] = 1'b1; ep[1] = 12'h1A1;
        ea[2] = 4'd0; eo[2] = 1'b0; ep[2] = 12'h000;
        scan("edge", 10'd1022, 9'd5, 3);

        // x_pos moved mid-frame: box stays at 1022 until the origin
        x_pos = 10'd10;
        ea[0] = 4'd0; eo[0] = 1'b0; ep[0] = 12'h000;
        ea[1] = 4'd0; eo[1] = 1'b0; ep[1] = 12'h000;
        scan("nolatch", 10'd10, 9'd5, 2);

        // advance to frame 1 off-origin, latch it, fetch from ROM 1
        moving = 1'b1;
        col_addr = 10'd700; row_addr = 9'd400;
        for (int i = 0; i < 5; i++) step();
        origin();
        check("f1_frame", 32'(frame_idx), 32'd1);
        ea[0] = 4'd0; eo[0] = 1'b1; ep[0] = 12'h2A0;
        ea[1] = 4'd1; eo[1] = 1'b1; ep[1] = 12'h2A1;
        scan("f1", 10'd10, 9'd5, 2);
        check("f1_hold", 32'(frame_idx), 32'd1);

        // reset in the middle of an opaque run
        col_addr = 10'd10; row_addr = 9'd5; step();
        col_addr = 10'd11; step();
        col_addr = 10'd12; rst = 1'b1; step();
        check("mrst_opq", 32'(pix_opaque), 32'd0);
        check("mrst_pix", 32'(pix_out), 32'd0);
        check("mrst_addr", 32'(rom_addr), 32'd0);
        check("mrst_frame", 32'(frame_idx), 32'd0);
        check("mrst_state", 32'(dut.r_state), 32'd0);
        rst = 1'b0; moving = 1'b0;
        step(); step(); step();
        check("mrst_next", 32'(dut.r_next_frame), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
